// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : State encoding, owner codes and abort data for mem_bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE    = 2'd0;
    localparam state_t c_ST_RD_BUSY = 2'd1;
    localparam state_t c_ST_WR_BUSY = 2'd2;
    localparam state_t c_ST_DONE    = 2'd3;

    typedef logic [1:0] owner_t;
    localparam owner_t c_OWN_NONE = 2'd0;
    localparam owner_t c_OWN_IF   = 2'd1;
    localparam owner_t c_OWN_DR   = 2'd2;
    localparam owner_t c_OWN_DW   = 2'd3;

    // Read data returned to the owner when a hung transaction is aborted
    localparam logic [31:0] c_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter_if
// Description : Requester-side and memory-side signals of mem_bus_arbiter.
//               master = arbiter view, slave = requesters/memory view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_read_req;
    logic          i_read_w;
    logic          i_read_hw;
    logic [AW-1:0] i_read_adr;
    logic          i_read_valid;

    logic          d_read_req;
    logic          d_read_w;
    logic          d_read_hw;
    logic [AW-1:0] d_read_adr;
    logic          d_read_valid;

    logic          d_write_req;
    logic          d_write_w;
    logic          d_write_hw;
    logic [AW-1:0] d_write_adr;
    logic [DW-1:0] d_write_data;
    logic          d_write_finish;

    logic [DW-1:0] rdata;

    logic          mem_req;
    logic          mem_we;
    logic          mem_w;
    logic          mem_hw;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          mem_wfinish;

    modport master (
        input  i_read_req, i_read_w, i_read_hw, i_read_adr,
        output i_read_valid,
        input  d_read_req, d_read_w, d_read_hw, d_read_adr,
        output d_read_valid,
        input  d_write_req, d_write_w, d_write_hw, d_write_adr, d_write_data,
        output d_write_finish,
        output rdata,
        output mem_req, mem_we, mem_w, mem_hw, mem_adr, mem_wdata,
        input  mem_rvalid, mem_rdata, mem_wfinish
    );

    modport slave (
        output i_read_req, i_read_w, i_read_hw, i_read_adr,
        input  i_read_valid,
        output d_read_req, d_read_w, d_read_hw, d_read_adr,
        input  d_read_valid,
        output d_write_req, d_write_w, d_write_hw, d_write_adr, d_write_data,
        input  d_write_finish,
        input  rdata,
        input  mem_req, mem_we, mem_w, mem_hw, mem_adr, mem_wdata,
        output mem_rvalid, mem_rdata, mem_wfinish
    );

endinterface
`default_nettype wire

// File: rtl/mem_arb_wdog.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_wdog
// Description : Transaction watchdog; flags a busy transaction that has run
//               TIMEOUT_CYC-1 cycles since its grant.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_wdog #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_clear,
    input  wire logic i_busy,
    output logic      o_expired
);

    localparam int             c_CW   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT_CYC - 1);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_busy) begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

    assign o_expired = i_busy && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Single-port memory arbiter for fetch, load and store with
//               fixed priority store > load > fetch and one transaction in
//               flight. Optional watchdog abort when MEM_ARB_TIMEOUT_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    mem_bus_arbiter_if.master   bus,
    output logic                arb_err
);

    state_t        r_state;
    owner_t        r_owner;
    logic          r_mem_req;
    logic          r_mem_we;
    logic          r_mem_w;
    logic          r_mem_hw;
    logic [AW-1:0] r_mem_adr;
    logic [DW-1:0] r_mem_wdata;

    logic w_grant;
    logic w_busy;
    logic w_resp;
    logic w_abort;
    logic w_done;

    assign w_grant = (r_state == c_ST_IDLE) &&
                     (bus.d_write_req || bus.d_read_req || bus.i_read_req);
    assign w_busy  = (r_state == c_ST_RD_BUSY) || (r_state == c_ST_WR_BUSY);

    // Only a response matching the transaction direction completes it
    assign w_resp  = ((r_state == c_ST_RD_BUSY) && bus.mem_rvalid) ||
                     ((r_state == c_ST_WR_BUSY) && bus.mem_wfinish);

`ifdef MEM_ARB_TIMEOUT_EN
    logic w_expired;
    logic r_err;

    mem_arb_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_grant),
        .i_busy    (w_busy),
        .o_expired (w_expired)
    );

    // A real response arriving on the last cycle takes precedence over abort
    assign w_abort = w_expired && !w_resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_abort) begin
            r_err <= 1'b1;
        end
    end

    assign arb_err = r_err;
`else
    assign w_abort = 1'b0;
    assign arb_err = 1'b0;
`endif

    assign w_done = w_resp || w_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_owner     <= c_OWN_NONE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_w     <= 1'b0;
            r_mem_hw    <= 1'b0;
            r_mem_adr   <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.d_write_req) begin
                        r_state     <= c_ST_WR_BUSY;
                        r_owner     <= c_OWN_DW;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_w     <= bus.d_write_w;
                        r_mem_hw    <= bus.d_write_hw;
                        r_mem_adr   <= bus.d_write_adr;
                        r_mem_wdata <= bus.d_write_data;
                    end else if (bus.d_read_req) begin
                        r_state   <= c_ST_RD_BUSY;
                        r_owner   <= c_OWN_DR;
                        r_mem_req <= 1'b1;
                        r_mem_we  <= 1'b0;
                        r_mem_w   <= bus.d_read_w;
                        r_mem_hw  <= bus.d_read_hw;
                        r_mem_adr <= bus.d_read_adr;
                    end else if (bus.i_read_req) begin
                        r_state   <= c_ST_RD_BUSY;
                        r_owner   <= c_OWN_IF;
                        r_mem_req <= 1'b1;
                        r_mem_we  <= 1'b0;
                        r_mem_w   <= bus.i_read_w;
                        r_mem_hw  <= bus.i_read_hw;
                        r_mem_adr <= bus.i_read_adr;
                    end
                end
                c_ST_RD_BUSY, c_ST_WR_BUSY: begin
                    if (w_done) begin
                        r_state   <= c_ST_DONE;
                        r_mem_req <= 1'b0;
                    end
                end
                c_ST_DONE: begin
                    // Dead cycle lets the served requester drop its level request
                    r_state <= c_ST_IDLE;
                    r_owner <= c_OWN_NONE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_owner <= c_OWN_NONE;
                end
            endcase
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_w     = r_mem_w;
    assign bus.mem_hw    = r_mem_hw;
    assign bus.mem_adr   = r_mem_adr;
    assign bus.mem_wdata = r_mem_wdata;

    assign bus.i_read_valid   = w_done && (r_state == c_ST_RD_BUSY) && (r_owner == c_OWN_IF);
    assign bus.d_read_valid   = w_done && (r_state == c_ST_RD_BUSY) && (r_owner == c_OWN_DR);
    assign bus.d_write_finish = w_done && (r_state == c_ST_WR_BUSY) && (r_owner == c_OWN_DW);

    assign bus.rdata = w_abort ? DW'(c_TIMEOUT_DATA) : bus.mem_rdata;

endmodule
`default_nettype wire
